// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences ECP5 EHXPLLL reset, lock qualification and system reset release
//
// Runs on the 25 MHz board reference clock, never on a PLL output. Each attempt
// pulses the PLL RST, waits for LOCK with a timeout, then requires LOCK to stay
// continuously high before releasing system reset. Lock loss in RUN reasserts
// system reset and restarts the sequence. After MAX_RETRIES failed attempts a
// sticky fail flag is raised until i_rst_n or i_force_relock.
// The PLL instance must have RST enabled (PLLRST_ENA="ENABLED").
// o_sys_rst_n is synchronous to i_clk; each PLL-output domain must re-synchronise
// its deassertion locally.
//
// Optional feature macro: PLL_RESET_CTRL_LOSS_CNT_EN
//   defined     -> o_loss_cnt counts lock-loss events in RUN, saturating at 255
//   not defined -> o_loss_cnt tied to 8'h00, no counter flops
//
// Ports:
//   i_clk          in   1  25 MHz reference clock
//   i_rst_n        in   1  synchronous active-low reset
//   i_pll_locked   in   1  PLL LOCK, asynchronous to i_clk
//   i_force_relock in   1  single-cycle pulse: restart the sequence from RESET_PLL
//   o_pll_rst      out  1  to PLL RST, active high
//   o_sys_rst_n    out  1  system reset, active low, registered
//   o_pll_ok       out  1  high iff in RUN
//   o_fail         out  1  sticky: retries exhausted
//   o_retry_cnt    out  4  failed attempts since last RUN entry / force_relock / reset
//   o_loss_cnt     out  8  lock-loss events in RUN, saturating
module pll_reset_ctrl #(
    parameter int SYNC_STAGES         = 2,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 2500,
    parameter int STABLE_CYCLES       = 256,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pll_locked,
    input  logic       i_force_relock,
    output logic       o_pll_rst,
    output logic       o_sys_rst_n,
    output logic       o_pll_ok,
    output logic       o_fail,
    output logic [3:0] o_retry_cnt,
    output logic [7:0] o_loss_cnt
);
    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE_WAIT,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] L_PULSE_END   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_TIMEOUT_END = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_STABLE_END  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       L_MAX_RETRIES = 4'(MAX_RETRIES);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pll_rst;
    logic                   r_sys_rst_n;
    logic                   r_pll_ok;
    logic                   r_fail;
    logic [3:0]             r_retry_cnt;
    logic                   w_locked_s;
    logic [3:0]             w_retry_inc;

    assign w_locked_s  = r_sync[SYNC_STAGES-1];
    assign w_retry_inc = r_retry_cnt + 4'd1;

    // LOCK comes from the PLL analog block; bring it into i_clk before any decision.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll_locked};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_pll_ok    <= 1'b0;
            r_fail      <= 1'b0;
            r_retry_cnt <= '0;
        end else if (i_force_relock) begin
            // Operator restart wins over every same-edge event and forgives past failures.
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_pll_ok    <= 1'b0;
            r_fail      <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == L_PULSE_END) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= S_STABLE_WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == L_TIMEOUT_END) begin
                        r_retry_cnt <= w_retry_inc;
                        r_cnt       <= '0;
                        if (w_retry_inc == L_MAX_RETRIES) begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state   <= S_RESET_PLL;
                            r_pll_rst <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE_WAIT: begin
                    // A drop during qualification is a wobble, not a failed attempt:
                    // go back to waiting with a fresh timeout and no retry charged.
                    if (!w_locked_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == L_STABLE_END) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        r_sys_rst_n <= 1'b1;
                        r_pll_ok    <= 1'b1;
                        r_retry_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        r_state     <= S_RESET_PLL;
                        r_cnt       <= '0;
                        r_pll_rst   <= 1'b1;
                        r_sys_rst_n <= 1'b0;
                        r_pll_ok    <= 1'b0;
                    end
                end
                S_FAIL: begin
                    r_pll_rst   <= 1'b0;
                    r_sys_rst_n <= 1'b0;
                    r_pll_ok    <= 1'b0;
                    r_fail      <= 1'b1;
                end
                default: begin
                    r_state     <= S_RESET_PLL;
                    r_cnt       <= '0;
                    r_pll_rst   <= 1'b1;
                    r_sys_rst_n <= 1'b0;
                    r_pll_ok    <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;
    logic       w_loss_evt;

    // A forced restart out of RUN is not a lock loss.
    assign w_loss_evt = (r_state == S_RUN) && !w_locked_s && !i_force_relock;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_loss_cnt <= '0;
        else if (w_loss_evt && r_loss_cnt != 8'hFF)
            r_loss_cnt <= r_loss_cnt + 8'd1;
    end

    assign o_loss_cnt = r_loss_cnt;
`else
    assign o_loss_cnt = 8'h00;
`endif

    assign o_pll_rst   = r_pll_rst;
    assign o_sys_rst_n = r_sys_rst_n;
    assign o_pll_ok    = r_pll_ok;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry_cnt;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: directed self-checking bench for pll_reset_ctrl
module tb_pll_reset_ctrl;
`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_ok;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pll_reset_ctrl #(
        .SYNC_STAGES(2),
        .RST_PULSE_CYCLES(4),
        .LOCK_TIMEOUT_CYCLES(20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES(2),
        .CNT_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_pll_locked(pll_locked),
        .i_force_relock(force_relock),
        .o_pll_rst(pll_rst),
        .o_sys_rst_n(sys_rst_n),
        .o_pll_ok(pll_ok),
        .o_fail(fail),
        .o_retry_cnt(retry_cnt),
        .o_loss_cnt(loss_cnt)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After this returns the next clock edge is edge 1 after release.
    task automatic do_reset(input logic locked);
        rst_n = 1'b0;
        pll_locked = locked;
        force_relock = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_force();
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_locked = 1'b0;
        step(2);
        checks++;
        if ({pll_rst, sys_rst_n, pll_ok, fail, retry_cnt, loss_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: got rst=%b srst_n=%b ok=%b fail=%b retry=%0d loss=%0d, want 1 0 0 0 0 0",
                     pll_rst, sys_rst_n, pll_ok, fail, retry_cnt, loss_cnt);
        end
    endtask

    task automatic test_power_up();
        do_reset(1'b1);
        for (int e = 1; e <= 3; e++) begin
            step(1);
            checks++;
            if (pll_rst !== 1'b1) begin
                errors++;
                $display("FAIL pu_pulse_high e%0d: pll_rst=%b want 1", e, pll_rst);
            end
        end
        step(1);
        checks++;
        if (pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL pu_pulse_end: pll_rst=%b want 0", pll_rst);
        end
        step(8);
        checks++;
        if ({sys_rst_n, pll_ok} !== 2'b00) begin
            errors++;
            $display("FAIL pu_early_release: srst_n=%b ok=%b want 0 0", sys_rst_n, pll_ok);
        end
        step(1);
        checks++;
        if ({sys_rst_n, pll_ok, pll_rst} !== 3'b110) begin
            errors++;
            $display("FAIL pu_release: srst_n=%b ok=%b rst=%b want 1 1 0", sys_rst_n, pll_ok, pll_rst);
        end
    endtask

    task automatic test_timeout_fail();
        do_reset(1'b0);
        step(4);
        checks++;
        if (pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse1_end: pll_rst=%b want 0", pll_rst);
        end
        step(19);
        checks++;
        if ({pll_rst, retry_cnt} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL to_pre_timeout1: rst=%b retry=%0d want 0 0", pll_rst, retry_cnt);
        end
        step(1);
        checks++;
        if ({pll_rst, retry_cnt, fail} !== {1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL to_timeout1: rst=%b retry=%0d fail=%b want 1 1 0", pll_rst, retry_cnt, fail);
        end
        step(3);
        checks++;
        if (pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse2_high: pll_rst=%b want 1", pll_rst);
        end
        step(1);
        checks++;
        if (pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse2_end: pll_rst=%b want 0", pll_rst);
        end
        step(19);
        checks++;
        if (fail !== 1'b0) begin
            errors++;
            $display("FAIL to_pre_timeout2: fail=%b want 0", fail);
        end
        step(1);
        checks++;
        if ({fail, retry_cnt, pll_rst, sys_rst_n} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL to_enter_fail: fail=%b retry=%0d rst=%b srst_n=%b want 1 2 0 0",
                     fail, retry_cnt, pll_rst, sys_rst_n);
        end
        step(30);
        checks++;
        if ({fail, retry_cnt, pll_rst} !== {1'b1, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL to_fail_held: fail=%b retry=%0d rst=%b want 1 2 0", fail, retry_cnt, pll_rst);
        end
        pulse_force();
        checks++;
        if ({fail, retry_cnt, pll_rst} !== {1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL to_force_exit: fail=%b retry=%0d rst=%b want 0 0 1", fail, retry_cnt, pll_rst);
        end
        step(3);
        checks++;
        if (pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL to_force_pulse: pll_rst=%b want 1", pll_rst);
        end
        step(1);
        checks++;
        if (pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL to_force_pulse_end: pll_rst=%b want 0", pll_rst);
        end
    endtask

    task automatic test_stable_glitch();
        do_reset(1'b1);
        step(10);
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
        checks++;
        if ({sys_rst_n, retry_cnt, pll_rst} !== {1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL sg_no_run: srst_n=%b retry=%0d rst=%b want 0 0 0", sys_rst_n, retry_cnt, pll_rst);
        end
        step(10);
        checks++;
        if (sys_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL sg_requalify: srst_n=%b want 0", sys_rst_n);
        end
        step(1);
        checks++;
        if ({sys_rst_n, pll_ok, retry_cnt} !== {1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL sg_run: srst_n=%b ok=%b retry=%0d want 1 1 0", sys_rst_n, pll_ok, retry_cnt);
        end
    endtask

    task automatic test_force_vs_timeout();
        do_reset(1'b0);
        step(24);
        checks++;
        if (retry_cnt !== 4'd1) begin
            errors++;
            $display("FAIL fvt_retry1: retry=%0d want 1", retry_cnt);
        end
        step(23);
        pulse_force();
        checks++;
        if ({pll_rst, retry_cnt, fail} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL fvt_priority: rst=%b retry=%0d fail=%b want 1 0 0", pll_rst, retry_cnt, fail);
        end
        step(3);
        checks++;
        if ({pll_rst, fail} !== 2'b10) begin
            errors++;
            $display("FAIL fvt_pulse: rst=%b fail=%b want 1 0", pll_rst, fail);
        end
        step(1);
        checks++;
        if (pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL fvt_pulse_end: pll_rst=%b want 0", pll_rst);
        end
    endtask

    task automatic test_latency_retry_clear();
        do_reset(1'b0);
        step(30);
        pll_locked = 1'b1;
        step(10);
        checks++;
        if ({sys_rst_n, retry_cnt} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL lat_pre: srst_n=%b retry=%0d want 0 1", sys_rst_n, retry_cnt);
        end
        step(1);
        checks++;
        if ({sys_rst_n, pll_ok, retry_cnt} !== {1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL lat_rise: srst_n=%b ok=%b retry=%0d want 1 1 0", sys_rst_n, pll_ok, retry_cnt);
        end
    endtask

    task automatic test_lock_loss();
        pulse_force();
        checks++;
        if ({pll_rst, sys_rst_n, pll_ok, loss_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL ll_force_run: rst=%b srst_n=%b ok=%b loss=%0d want 1 0 0 0",
                     pll_rst, sys_rst_n, pll_ok, loss_cnt);
        end
        step(13);
        checks++;
        if (sys_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL ll_force_rerun: srst_n=%b want 1", sys_rst_n);
        end
        for (int i = 1; i <= 300; i++) begin
            logic [7:0] exp_loss;
            exp_loss = LOSS_EN ? ((i > 255) ? 8'd255 : 8'(i)) : 8'd0;
            pll_locked = 1'b0;
            step(2);
            checks++;
            if (sys_rst_n !== 1'b1) begin
                errors++;
                $display("FAIL ll_early_drop i%0d: srst_n=%b want 1", i, sys_rst_n);
            end
            step(1);
            checks++;
            if ({sys_rst_n, pll_ok, pll_rst, loss_cnt} !== {1'b0, 1'b0, 1'b1, exp_loss}) begin
                errors++;
                $display("FAIL ll_drop i%0d: srst_n=%b ok=%b rst=%b loss=%0d want 0 0 1 %0d",
                         i, sys_rst_n, pll_ok, pll_rst, loss_cnt, exp_loss);
            end
            pll_locked = 1'b1;
            step(13);
            checks++;
            if (sys_rst_n !== 1'b1) begin
                errors++;
                $display("FAIL ll_rerun i%0d: srst_n=%b want 1", i, sys_rst_n);
            end
        end
    endtask

    task automatic test_reset_mid_stable();
        pulse_force();
        step(6);
        checks++;
        if ({pll_rst, sys_rst_n} !== 2'b00) begin
            errors++;
            $display("FAIL rms_in_stable: rst=%b srst_n=%b want 0 0", pll_rst, sys_rst_n);
        end
        rst_n = 1'b0;
        step(1);
        checks++;
        if ({pll_rst, sys_rst_n, pll_ok, fail, retry_cnt, loss_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            errors++;
            $display("FAIL rms_reset: rst=%b srst_n=%b ok=%b fail=%b retry=%0d loss=%0d want 1 0 0 0 0 0",
                     pll_rst, sys_rst_n, pll_ok, fail, retry_cnt, loss_cnt);
        end
        rst_n = 1'b1;
        step(3);
        checks++;
        if (pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL rms_pulse: pll_rst=%b want 1", pll_rst);
        end
        step(1);
        checks++;
        if (pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL rms_pulse_end: pll_rst=%b want 0", pll_rst);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_timeout_fail();
        test_stable_glitch();
        test_force_vs_timeout();
        test_latency_retry_clear();
        test_lock_loss();
        test_reset_mid_stable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
